// File: rtl/d_uncache_ctrl_pkg.sv
// Shared definitions for the uncached data access controller:
// FSM states, AXI transfer size codes and the fixed AXI transaction ID.
package d_uncache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        DONE
    } state_t;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    localparam int AXI_ID = 1;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        case (size)
            2'd0:    return SIZE_B;
            2'd1:    return SIZE_H;
            2'd2:    return SIZE_W;
            default: return {1'b0, size};
        endcase
    endfunction

endpackage

// File: rtl/d_uncache_ctrl.sv
// M-stage controller for uncached (kseg1) data accesses: one single-beat AXI
// read or write per request, stalling the pipeline until the bus completes.
module d_uncache_ctrl
    import d_uncache_ctrl_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_en,
    input  logic              no_cache,
    input  logic [3:0]        req_wen,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_paddr,
    input  logic [31:0]       req_wdata,
    input  logic              pipe_stall,
    output logic              stall,
    output logic [31:0]       rdata,

    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,

    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,

    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                aw_done;
    logic                w_done;

    logic hit;
    logic aw_fire;
    logic w_fire;

    // Responses are single beat and bus errors are not reported to the core.
    logic unused_resp;
    assign unused_resp = &{1'b0, rresp, rlast, bresp};

    assign hit     = req_en & no_cache;
    assign stall   = hit & (state != DONE);
    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;

    assign arid   = ID_W'(AXI_ID);
    assign awid   = ID_W'(AXI_ID);
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arlen  = 8'd0;
    assign awlen  = 8'd0;
    assign arsize = axi_size(size_q);
    assign awsize = axi_size(size_q);
    assign wlast  = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            rdata   <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        addr_q <= req_paddr;
                        size_q <= req_size;
                        if (req_wen == 4'd0) begin
                            arvalid <= 1'b1;
                            state   <= RD_A;
                        end else begin
                            wdata   <= req_wdata;
                            wstrb   <= req_wen;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        rdata  <= rdata_i;
                        state  <= DONE;
                    end
                end
                // Address and data channels complete independently, in any order.
                WR: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_fire) & (w_done | w_fire)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= DONE;
                    end
                end
                // Single release point: the M stage advances out of here exactly once.
                DONE: begin
                    if (!pipe_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_uncache_ctrl.sv
// Randomized self-checking bench for d_uncache_ctrl; a responsive AXI slave with
// programmable latencies and a transaction-level model of stall length and data.
module tb_d_uncache_ctrl;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_en;
    logic              no_cache;
    logic [3:0]        req_wen;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_paddr;
    logic [31:0]       req_wdata;
    logic              pipe_stall;
    logic              stall;
    logic [31:0]       rdata;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata_i;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = 32'd0;

    d_uncache_ctrl #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .no_cache(no_cache), .req_wen(req_wen), .req_size(req_size),
        .req_paddr(req_paddr), .req_wdata(req_wdata), .pipe_stall(pipe_stall),
        .stall(stall), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rdata_i(rdata_i), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request presented in M stage; the slave answers after da/dw/dr_db cycles
    // of valid (or ready) and the pipeline holds in DONE for ps_len extra cycles.
    task automatic applyStimulus(input bit is_store, input bit cached,
                                 input logic [31:0] addr, input logic [1:0] size,
                                 input logic [3:0] wen, input logic [31:0] wd,
                                 input logic [31:0] rd_val, input int da, input int dw,
                                 input int dr_db, input int ps_len, input int cached_cycles);
        int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
        int ar_seen = 0, r_seen = 0, aw_seen = 0, w_seen = 0, b_seen = 0;
        int stall_cycles = 0, cyc = 0, hold_bad = 0, act = 0, exp_stall;
        bit done = 1'b0;
        @(negedge clk);
        req_en    = 1'b1;
        no_cache  = ~cached;
        req_wen   = is_store ? wen : 4'd0;
        req_size  = size;
        req_paddr = addr;
        req_wdata = wd;
        if (cached) begin
            repeat (cached_cycles) begin
                #1;
                if (stall) stall_cycles++;
                if (arvalid | awvalid | wvalid | rready | bready) act++;
                pipe_stall = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            checkOutput("cached_stall", 32'(stall_cycles), 32'd0);
            checkOutput("cached_axi", 32'(act), 32'd0);
            req_en = 1'b0;
            pipe_stall = 1'b0;
            return;
        end
        while (!done && cyc < 200) begin
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_cycles++;
                arready = arvalid && (ar_seen + 1 >= da);
                rvalid  = rready  && (r_seen + 1 >= dr_db);
                awready = awvalid && (aw_seen + 1 >= da);
                wready  = wvalid  && (w_seen + 1 >= dw);
                bvalid  = bready  && (b_seen + 1 >= dr_db);
                rdata_i = rvalid ? rd_val : $urandom();
                if (arvalid && arready) begin
                    ar_n++;
                    checkOutput("araddr", araddr, addr);
                    checkOutput("arsize", 32'(arsize), {30'd0, size});
                end else if (arvalid) ar_seen++;
                if (rvalid) r_n++;
                else if (rready) r_seen++;
                if (awvalid && awready) begin
                    aw_n++;
                    checkOutput("awaddr", awaddr, addr);
                    checkOutput("awsize", 32'(awsize), {30'd0, size});
                end else if (awvalid) aw_seen++;
                if (wvalid && wready) begin
                    w_n++;
                    checkOutput("wdata", wdata, wd);
                    checkOutput("wstrb", 32'(wstrb), {28'd0, wen});
                end else if (wvalid) w_seen++;
                if (bvalid) b_n++;
                else if (bready) b_seen++;
                pipe_stall = 1'($urandom_range(0, 1));
                @(negedge clk);
                cyc++;
            end
        end
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        if (!done) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            rst = 1'b1; req_en = 1'b0; pipe_stall = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            last_rdata = 32'd0;
            return;
        end
        exp_stall = is_store ? 1 + ((da > dw) ? da : dw) + dr_db : 1 + da + dr_db;
        checkOutput("stall_len", 32'(stall_cycles), 32'(exp_stall));
        checkOutput("n_ar", 32'(ar_n), is_store ? 32'd0 : 32'd1);
        checkOutput("n_r",  32'(r_n),  is_store ? 32'd0 : 32'd1);
        checkOutput("n_aw", 32'(aw_n), is_store ? 32'd1 : 32'd0);
        checkOutput("n_w",  32'(w_n),  is_store ? 32'd1 : 32'd0);
        checkOutput("n_b",  32'(b_n),  is_store ? 32'd1 : 32'd0);
        if (!is_store) last_rdata = rd_val;
        checkOutput("rdata", rdata, last_rdata);
        pipe_stall = (ps_len > 0);
        for (int i = 0; i < ps_len; i++) begin
            @(negedge clk);
            #1;
            if (stall || arvalid || awvalid || wvalid || rready || bready || rdata !== last_rdata)
                hold_bad++;
            pipe_stall = (i < ps_len - 1);
        end
        if (ps_len > 0) checkOutput("done_hold", 32'(hold_bad), 32'd0);
    endtask

    // Reset while a read response is being offered must abandon it entirely.
    task automatic applyResetMidRead();
        bit seen = 1'b0;
        @(negedge clk);
        req_en = 1'b1; no_cache = 1'b1; req_wen = 4'd0; req_size = 2'd2;
        req_paddr = 32'h1FC0_0010; pipe_stall = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (rready) seen = 1'b1;
            else begin
                arready = arvalid;
                @(negedge clk);
            end
        end
        arready = 1'b0;
        checkOutput("rst_reach_rd_d", 32'(seen), 32'd1);
        rvalid = 1'b1; rdata_i = 32'hCAFE_F00D; rst = 1'b1; req_en = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_rready", 32'(rready), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b0; rst = 1'b0;
        last_rdata = 32'd0;
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        rst = 1'b1; req_en = 1'b0; no_cache = 1'b0; req_wen = 4'd0; req_size = 2'd0;
        req_paddr = '0; req_wdata = '0; pipe_stall = 1'b0;
        arready = 1'b0; rdata_i = '0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("const_lens", {16'd0, arlen, awlen}, 32'd0);
        checkOutput("const_ids", {24'd0, arid, awid}, 32'h11);
        checkOutput("const_wlast", 32'(wlast), 32'd1);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'h1FAF_0000, 2'd2, 4'd0, 32'd0, 32'hDEAD_BEEF, 2, 1, 3, 0, 0);
        applyStimulus(1'b1, 1'b0, 32'h1FAF_0012, 2'd0, 4'b0100, 32'h00AB_0000, 32'd0, 3, 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b0, 32'h1FAF_0022, 2'd0, 4'b0100, 32'h00AB_0000, 32'd0, 2, 2, 2, 0, 0);
        applyStimulus(1'b0, 1'b0, 32'h1FAF_0100, 2'd1, 4'd0, 32'd0, 32'h1234_5678, 1, 1, 2, 3, 0);
        applyResetMidRead();
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, 2'd2, 4'd0, 32'd0, 32'd0, 1, 1, 1, 0, 10);
        applyStimulus(1'b0, 1'b0, 32'h1FD0_0004, 2'd2, 4'd0, 32'd0, 32'hA5A5_0F0F, 1, 1, 1, 0, 0);
        applyStimulus(1'b1, 1'b0, 32'h1FD0_0008, 2'd2, 4'hF, 32'h0BAD_F00D, 32'd0, 1, 3, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            a = $urandom() & 32'h1FFF_FFFF;
            applyStimulus(kind >= 3, kind == 0, a, 2'($urandom_range(0, 2)),
                          4'($urandom_range(1, 15)), $urandom(), $urandom(),
                          $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                          $urandom_range(0, 3), 2);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                req_en = 1'b0;
                #1;
                checkOutput("gap_stall", 32'(stall), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
